// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline stages.
package mips_pkg;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats freeze, freeze beats load, otherwise a bubble.
module if_id_reg
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               freeze,
   input  logic               load,
   input  logic [ADDR_W-1:0]  load_pc,
   input  logic [INSTR_W-1:0] load_instr,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic               if_id_valid
);

   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;

   always_comb begin
      pc_d    = '0;
      instr_d = INSTR_W'(NOP_INSTR);
      valid_d = 1'b0;
      if (flush) begin
         pc_d    = '0;
         instr_d = INSTR_W'(NOP_INSTR);
         valid_d = 1'b0;
      end else if (freeze) begin
         pc_d    = pc_q;
         instr_d = instr_q;
         valid_d = valid_q;
      end else if (load) begin
         pc_d    = load_pc;
         instr_d = load_instr;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         instr_q <= INSTR_W'(NOP_INSTR);
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign if_id_pc    = pc_q;
   assign if_id_instr = instr_q;
   assign if_id_valid = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, hold buffer and IF/ID register.
module if_fetch_unit
   import mips_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze,
   input  logic               branch_taken,
   input  logic [ADDR_W-1:0]  branch_addr,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ready,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic               if_id_valid
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
   logic               kill_q, kill_d;
   logic [ADDR_W-1:0]  hold_pc_q, hold_pc_d;
   logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;

   logic               deliver;
   logic [ADDR_W-1:0]  deliver_pc;
   logic [INSTR_W-1:0] deliver_instr;
   logic [ADDR_W-1:0]  req_pc_inc;

   assign req_pc_inc = req_pc_q + ADDR_W'(PC_INC);
   assign imem_req   = (state_q == S_REQ) && !rst;
   assign imem_addr  = pc_q;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      req_pc_d      = req_pc_q;
      kill_d        = kill_q;
      hold_pc_d     = hold_pc_q;
      hold_instr_d  = hold_instr_q;
      deliver       = 1'b0;
      deliver_pc    = hold_pc_q;
      deliver_instr = hold_instr_q;

      unique case (state_q)
         S_REQ: begin
            if (imem_ready) begin
               state_d  = S_WAIT;
               req_pc_d = pc_q;
               // A redirect in the accept cycle still leaves the old-PC response to absorb.
               kill_d   = branch_taken;
            end
            if (branch_taken) begin
               pc_d = branch_addr;
            end
         end

         S_WAIT: begin
            if (imem_rvalid) begin
               if (kill_q || branch_taken) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
                  if (branch_taken) begin
                     pc_d = branch_addr;
                  end
               end else begin
                  pc_d = req_pc_inc;
                  if (freeze) begin
                     hold_pc_d    = req_pc_inc;
                     hold_instr_d = imem_rdata;
                     state_d      = S_HOLD;
                  end else begin
                     deliver       = 1'b1;
                     deliver_pc    = req_pc_inc;
                     deliver_instr = imem_rdata;
                     state_d       = S_REQ;
                  end
               end
            end else if (branch_taken) begin
               pc_d   = branch_addr;
               kill_d = 1'b1;
            end
         end

         S_HOLD: begin
            if (branch_taken) begin
               pc_d    = branch_addr;
               state_d = S_REQ;
            end else if (!freeze) begin
               deliver = 1'b1;
               state_d = S_REQ;
            end
         end

         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         req_pc_q     <= '0;
         kill_q       <= 1'b0;
         hold_pc_q    <= '0;
         hold_instr_q <= INSTR_W'(NOP_INSTR);
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         kill_q       <= kill_d;
         hold_pc_q    <= hold_pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   if_id_reg #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_if_id_reg (
      .clk         (clk),
      .rst         (rst),
      .flush       (branch_taken),
      .freeze      (freeze),
      .load        (deliver),
      .load_pc     (deliver_pc),
      .load_instr  (deliver_instr),
      .if_id_pc    (if_id_pc),
      .if_id_instr (if_id_instr),
      .if_id_valid (if_id_valid)
   );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a configurable-latency instruction memory model.
module tb_if_fetch_unit;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic        if_id_valid;

   int n_pass;
   int n_total;

   if_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .ADDR_W   (32),
      .INSTR_W  (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .if_id_pc     (if_id_pc),
      .if_id_instr  (if_id_instr),
      .if_id_valid  (if_id_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   // Memory: response arrives lat cycles after acceptance, one outstanding.
   int          lat;
   logic        pend;
   int          cnt;
   logic [31:0] paddr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_rvalid <= 1'b0;
         imem_rdata  <= '0;
         pend        <= 1'b0;
         cnt         <= 0;
         paddr       <= '0;
      end else begin
         imem_rvalid <= 1'b0;
         if (pend) begin
            if (cnt <= 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= instr_of(paddr);
               pend        <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
         if (imem_req && imem_ready) begin
            if (lat <= 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= instr_of(imem_addr);
            end else begin
               pend  <= 1'b1;
               cnt   <= lat - 1;
               paddr <= imem_addr;
            end
         end
      end
   end

   typedef struct {
      logic        fz;
      logic        bt;
      logic [31:0] baddr;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } vec_t;

   vec_t tbl[29];

   function automatic vec_t mk(input logic fz, input logic bt, input logic [31:0] baddr,
                               input logic rdy, input logic req, input logic [31:0] addr,
                               input logic valid, input logic [31:0] pc,
                               input logic [31:0] instr);
      vec_t v;
      v.fz = fz; v.bt = bt; v.baddr = baddr; v.rdy = rdy;
      v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.instr = instr;
      return v;
   endfunction

   task automatic chk(input string name, input logic req, input logic [31:0] addr,
                      input logic valid, input logic [31:0] pc, input logic [31:0] instr);
      n_total++;
      if (imem_req === req && imem_addr === addr && if_id_valid === valid &&
          if_id_pc === pc && if_id_instr === instr) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got req=%0b addr=%h valid=%0b pc=%h instr=%h, want req=%0b addr=%h valid=%0b pc=%h instr=%h",
                  name, imem_req, imem_addr, if_id_valid, if_id_pc, if_id_instr,
                  req, addr, valid, pc, instr);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      n_pass       = 0;
      n_total      = 0;
      lat          = 1;
      rst          = 1'b1;
      freeze       = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = '0;
      imem_ready   = 1'b1;

      tbl[0]  = mk(0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0,   32'h0);
      tbl[1]  = mk(0, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,   32'h0);
      tbl[2]  = mk(0, 0, 32'h0,         1, 1, 32'h4,         1, 32'h4,   instr_of(32'h0));
      tbl[3]  = mk(0, 0, 32'h0,         1, 0, 32'h4,         0, 32'h0,   32'h0);
      tbl[4]  = mk(1, 0, 32'h0,         1, 1, 32'h8,         1, 32'h8,   instr_of(32'h4));
      tbl[5]  = mk(1, 0, 32'h0,         1, 0, 32'h8,         1, 32'h8,   instr_of(32'h4));
      tbl[6]  = mk(1, 0, 32'h0,         1, 0, 32'hC,         1, 32'h8,   instr_of(32'h4));
      tbl[7]  = mk(0, 0, 32'h0,         1, 0, 32'hC,         1, 32'h8,   instr_of(32'h4));
      tbl[8]  = mk(0, 0, 32'h0,         1, 1, 32'hC,         1, 32'hC,   instr_of(32'h8));
      tbl[9]  = mk(0, 0, 32'h0,         1, 0, 32'hC,         0, 32'h0,   32'h0);
      tbl[10] = mk(0, 1, 32'h20,        1, 1, 32'h10,        1, 32'h10,  instr_of(32'hC));
      tbl[11] = mk(0, 0, 32'h0,         1, 0, 32'h20,        0, 32'h0,   32'h0);
      tbl[12] = mk(0, 0, 32'h0,         1, 1, 32'h20,        0, 32'h0,   32'h0);
      tbl[13] = mk(0, 1, 32'h100,       1, 0, 32'h20,        0, 32'h0,   32'h0);
      tbl[14] = mk(0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h0,   32'h0);
      tbl[15] = mk(0, 0, 32'h0,         1, 0, 32'h100,       0, 32'h0,   32'h0);
      tbl[16] = mk(1, 1, 32'h200,       1, 1, 32'h104,       1, 32'h104, instr_of(32'h100));
      tbl[17] = mk(0, 0, 32'h0,         1, 0, 32'h200,       0, 32'h0,   32'h0);
      for (int i = 18; i <= 22; i++) begin
         tbl[i] = mk(0, 0, 32'h0,       0, 1, 32'h200,       0, 32'h0,   32'h0);
      end
      tbl[23] = mk(0, 0, 32'h0,         1, 1, 32'h200,       0, 32'h0,   32'h0);
      tbl[24] = mk(0, 0, 32'h0,         1, 0, 32'h200,       0, 32'h0,   32'h0);
      tbl[25] = mk(0, 1, 32'hFFFF_FFFC, 0, 1, 32'h204,       1, 32'h204, instr_of(32'h200));
      tbl[26] = mk(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h0,   32'h0);
      tbl[27] = mk(0, 0, 32'h0,         1, 0, 32'hFFFF_FFFC, 0, 32'h0,   32'h0);
      tbl[28] = mk(0, 0, 32'h0,         0, 1, 32'h0,         1, 32'h0,   instr_of(32'hFFFF_FFFC));

      repeat (2) cyc();
      chk("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;

      // Table: outputs observed at this negedge, then inputs for the next rising edge.
      for (int i = 0; i < 29; i++) begin
         #1;
         chk($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid, tbl[i].pc,
             tbl[i].instr);
         freeze       = tbl[i].fz;
         branch_taken = tbl[i].bt;
         branch_addr  = tbl[i].baddr;
         imem_ready   = tbl[i].rdy;
         @(negedge clk);
      end

      // Redirect while waiting on a slow response: the stale response must be dropped.
      #1;
      lat        = 3;
      imem_ready = 1'b1;
      cyc();
      branch_taken = 1'b1;
      branch_addr  = 32'h300;
      cyc();
      branch_taken = 1'b0;
      chk("kill_wait", 1'b0, 32'h300, 1'b0, 32'h0, 32'h0);
      cyc();
      chk("kill_still_wait", 1'b0, 32'h300, 1'b0, 32'h0, 32'h0);
      cyc();
      chk("kill_refetch", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0);
      got = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
         cyc();
         got = if_id_valid;
      end
      if (got) begin
         chk("slow_deliver", 1'b1, 32'h304, 1'b1, 32'h304, instr_of(32'h300));
      end else begin
         n_total++;
         $display("FAIL slow_deliver: got no valid IF/ID within 10 cycles, want pc=00000304");
      end

      // Response parked in the hold buffer, then dropped by a redirect.
      lat    = 1;
      freeze = 1'b1;
      cyc();
      cyc();
      chk("hold_enter", 1'b0, 32'h308, 1'b1, 32'h304, instr_of(32'h300));
      branch_taken = 1'b1;
      branch_addr  = 32'h400;
      cyc();
      branch_taken = 1'b0;
      freeze       = 1'b0;
      chk("hold_flush", 1'b1, 32'h400, 1'b0, 32'h0, 32'h0);
      cyc();
      cyc();
      chk("after_hold", 1'b1, 32'h404, 1'b1, 32'h404, instr_of(32'h400));

      // Asynchronous reset in the middle of a slow fetch.
      lat    = 3;
      freeze = 1'b1;
      cyc();
      chk("pre_rst", 1'b0, 32'h404, 1'b1, 32'h404, instr_of(32'h400));
      rst = 1'b1;
      #1;
      chk("rst_async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      cyc();
      cyc();
      rst    = 1'b0;
      freeze = 1'b0;
      lat    = 1;
      #1;
      chk("rst_refetch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      cyc();
      cyc();
      chk("rst_first", 1'b1, 32'h4, 1'b1, 32'h4, instr_of(32'h0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Drives PC, issues one-outstanding requests to a variable-latency instruction memory, and presents {pc+4, instr, valid} to the ID stage.
- Consumes the hazard unit's stall output (freeze) and the EXE stage's branch redirect (branch_taken, branch_addr).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- freeze  in  1  stall from hazard detection; IF/ID must hold.
- branch_taken  in  1  redirect from EXE; flushes IF/ID and in-flight fetch.
- branch_addr  in  ADDR_W  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_ready  in  1  memory accepts request this cycle (handshake when imem_req && imem_ready).
- imem_rvalid  in  1  response valid; exactly one response per accepted request, earliest the cycle after acceptance.
- imem_rdata  in  INSTR_W  fetched instruction.
- if_id_pc  out  ADDR_W  registered fetch address + 4.
- if_id_instr  out  INSTR_W  registered instruction (0 = NOP when invalid).
- if_id_valid  out  1  registered valid.

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=S_REQ, kill=0, hold buffer empty.
  - if_id_pc=0, if_id_instr=0, if_id_valid=0.
  - imem_req forced 0 while rst=1.
- imem_req = (state==S_REQ) && !rst; imem_addr = pc. Both are combinational from state/pc.
- S_REQ:
  - On imem_ready -> S_WAIT; captures req_pc=pc.
  - On branch_taken the same cycle, pc<=branch_addr.
  - If branch_taken && imem_ready, also set kill=1 (the old-PC request is already accepted).
- S_WAIT:
  - branch_taken without rvalid: pc<=branch_addr, kill<=1, stay.
  - rvalid while kill=1, or rvalid with branch_taken: discard data, kill<=0, -> S_REQ. pc is the target (newly loaded if branch_taken this cycle).
  - rvalid, !freeze: IF/ID <= {req_pc+4, rdata, 1}; pc<=req_pc+4; -> S_REQ.
  - rvalid, freeze: store {req_pc+4, rdata} in hold buffer; pc<=req_pc+4; -> S_HOLD.
- S_HOLD:
  - branch_taken: drop buffer, pc<=branch_addr, -> S_REQ.
  - !freeze: IF/ID <= buffer with valid=1; -> S_REQ.
  - else stay.
- IF/ID update priority per cycle:
  1. branch_taken: load {0,0,0}, i.e. flush. Overrides freeze.
  2. freeze: hold current contents.
  3. Deliver new instruction, from rdata or the hold buffer.
  4. Otherwise load the bubble {0,0,0}.
- Latency: with imem_ready=1 and 1-cycle memory, each instruction takes 2 cycles from request to IF/ID. Throughput is one instruction per 2 cycles; there is no pipelined prefetch.
- Address arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0. The low two bits are passed through unchanged and not checked.
- Reset mid-fetch: in-flight response is ignored after reset. The memory must be reset together with the core.

Decomposition:
- Shared package (mips_pkg): fetch state enum {S_REQ, S_WAIT, S_HOLD}, NOP encoding 32'h0, PC increment constant 4.
- One natural sub-module: if_id_reg, the IF/ID register with flush/freeze/load priority.
- FSM, pc, and hold buffer stay in the top.

Test Plan:
- Reset release, RESET_PC=0, imem_ready=1, 1-cycle memory returning addr-derived data -> imem_addr sequence 0,4,8. if_id_pc 4,8,12 with valid=1 every 2nd cycle, bubbles between.
- freeze=1 for 3 cycles while rvalid arrives for pc=8 -> IF/ID holds the pc=4 entry. After freeze drops, if_id_pc=12 with correct instr. No fetch is lost or duplicated.
- branch_taken=1, branch_addr=0x100 while in S_WAIT for pc=0x20 -> IF/ID flushed that cycle. The 0x20 response is discarded. The next request is at 0x100 and if_id_pc=0x104.
- branch_taken && freeze same cycle -> if_id_valid=0 next cycle (flush wins). pc=branch_addr.
- imem_ready held low 5 cycles -> imem_req stays 1 with a stable address, no state change. Assert rst mid-S_WAIT -> all outputs 0 immediately, refetch from RESET_PC.
- pc=0xFFFF_FFFC fetch -> if_id_pc=0x0000_0000, next imem_addr=0.
